// File: rtl/clock_pkg.sv
// Shared constants for the BCD time-of-day counter: FSM state codes,
// digit limits, packed-field offsets and BCD helper functions.
package clock_pkg;

   localparam logic [1:0] ST_STOP = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_LOAD = 2'd2;

   localparam logic [3:0] SEC_TENS_MAX = 4'd5;
   localparam logic [3:0] DIGIT_MAX    = 4'd9;
   localparam logic [7:0] MIN_SEC_MAX  = 8'h59;

   localparam int FIELD_W = 8;
   localparam int SS_LSB  = 0;
   localparam int MM_LSB  = 8;
   localparam int HH_LSB  = 16;

   function automatic logic bcd_field_ok(input logic [7:0] v, input logic [3:0] tens_max);
      return (v[3:0] <= DIGIT_MAX) && (v[7:4] <= tens_max);
   endfunction

   // Two-digit BCD increment that wraps to 00 after max_v.
   function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] max_v);
      logic [7:0] r;
      if (v == max_v) begin
         r = 8'h00;
      end else if (v[3:0] == DIGIT_MAX) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter modulo MOD with synchronous load and a same-cycle
// wrap strobe used to ripple carries into the next field.
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter int MOD = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] val,
   output logic       wrap
);

   localparam logic [7:0] MAX_BCD = {4'((MOD - 1) / 10), 4'((MOD - 1) % 10)};

   logic [7:0] val_q, val_d;
   logic       at_max_s;

   always_comb begin
      at_max_s = (val_q == MAX_BCD);
      val_d    = val_q;
      if (load) begin
         val_d = load_val;
      end else if (inc) begin
         val_d = bcd_step(val_q, MAX_BCD);
      end else begin
         val_d = val_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         val_q <= 8'h00;
      end else begin
         val_q <= val_d;
      end
   end

   assign wrap = inc && !load && at_max_s;
   assign val  = val_q;

endmodule

// File: rtl/clock_time_counter.sv
// Time-of-day counter hh:mm:ss in packed BCD with load handshake and day rollover.
// Optional alarm compiled in with CLOCK_TIME_COUNTER_ALARM_EN.
module clock_time_counter
   import clock_pkg::*;
#(
   parameter int HOUR_MOD = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        run,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [23:0] load_time,
   output logic        load_err,
   output logic [23:0] time_bcd,
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
   input  logic        alarm_set,
   input  logic [15:0] alarm_time,
   input  logic        alarm_on,
   output logic        alarm_hit,
`endif
   output logic        day_wrap
);

   localparam logic [7:0] HOUR_MAX = {4'((HOUR_MOD - 1) / 10), 4'((HOUR_MOD - 1) % 10)};

   logic [1:0] state_q, state_d;
   logic       load_ready_q, load_ready_d;
   logic       load_err_q, load_err_d;
   logic       day_wrap_q, day_wrap_d;
   logic       hs_s, fields_ok_s, load_ok_s, inc_s;
   logic       sec_wrap_s, min_wrap_s, hr_wrap_s;
   logic [7:0] ss_s, mm_s, hh_s;
   logic [7:0] ld_ss_s, ld_mm_s, ld_hh_s;

   assign ld_ss_s = load_time[SS_LSB +: FIELD_W];
   assign ld_mm_s = load_time[MM_LSB +: FIELD_W];
   assign ld_hh_s = load_time[HH_LSB +: FIELD_W];

   // A handshake of any kind, accepted or rejected, consumes the cycle's tick.
   always_comb begin
      hs_s        = load_valid && load_ready_q;
      fields_ok_s = bcd_field_ok(ld_ss_s, SEC_TENS_MAX) && bcd_field_ok(ld_mm_s, SEC_TENS_MAX)
                    && (ld_hh_s[3:0] <= DIGIT_MAX) && (ld_hh_s <= HOUR_MAX);
      load_ok_s   = hs_s && fields_ok_s;
      load_err_d  = hs_s && !fields_ok_s;
      inc_s       = tick && (state_q == ST_RUN) && !hs_s;
   end

   always_comb begin
      state_d = ST_STOP;
      if (load_ok_s) begin
         state_d = ST_LOAD;
      end else begin
         case (state_q)
            ST_STOP, ST_RUN, ST_LOAD: state_d = run ? ST_RUN : ST_STOP;
            default:                  state_d = ST_STOP;
         endcase
      end
      load_ready_d = (state_d != ST_LOAD);
   end

   assign day_wrap_d = hr_wrap_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_STOP;
         load_ready_q <= 1'b1;
         load_err_q   <= 1'b0;
         day_wrap_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_ready_q <= load_ready_d;
         load_err_q   <= load_err_d;
         day_wrap_q   <= day_wrap_d;
      end
   end

   bcd_mod_counter #(.MOD(60)) u_ss (
      .clk(clk), .rst(rst), .inc(inc_s), .load(load_ok_s),
      .load_val(ld_ss_s), .val(ss_s), .wrap(sec_wrap_s)
   );

   bcd_mod_counter #(.MOD(60)) u_mm (
      .clk(clk), .rst(rst), .inc(sec_wrap_s), .load(load_ok_s),
      .load_val(ld_mm_s), .val(mm_s), .wrap(min_wrap_s)
   );

   bcd_mod_counter #(.MOD(HOUR_MOD)) u_hh (
      .clk(clk), .rst(rst), .inc(min_wrap_s), .load(load_ok_s),
      .load_val(ld_hh_s), .val(hh_s), .wrap(hr_wrap_s)
   );

`ifdef CLOCK_TIME_COUNTER_ALARM_EN
   logic [15:0] alarm_q, alarm_d;
   logic        alarm_hit_q, alarm_hit_d;
   logic [7:0]  mm_adv_s, hh_adv_s;

   // Match against the hh:mm being entered, so only a tick-driven minute rollover can hit.
   always_comb begin
      alarm_d     = alarm_set ? alarm_time : alarm_q;
      mm_adv_s    = bcd_step(mm_s, MIN_SEC_MAX);
      hh_adv_s    = min_wrap_s ? bcd_step(hh_s, HOUR_MAX) : hh_s;
      alarm_hit_d = alarm_on && sec_wrap_s && ({hh_adv_s, mm_adv_s} == alarm_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_q     <= 16'h0000;
         alarm_hit_q <= 1'b0;
      end else begin
         alarm_q     <= alarm_d;
         alarm_hit_q <= alarm_hit_d;
      end
   end

   assign alarm_hit = alarm_hit_q;
`endif

   assign load_ready = load_ready_q;
   assign load_err   = load_err_q;
   assign day_wrap   = day_wrap_q;
   assign time_bcd   = {hh_s, mm_s, ss_s};

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter: a 24-hour and a 12-hour instance share one
// stimulus stream and are checked against a seconds-of-day reference model.
module tb_clock_time_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, tick, run, load_valid;
   logic [23:0] load_time;
   logic        rdy24, err24, dw24, rdy12, err12, dw12;
   logic [23:0] t24, t12;
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
   logic        alarm_set, alarm_on, ah24, ah12;
   logic [15:0] alarm_time;
`endif

   int vectors     = 0;
   int miscompares = 0;

   int          hmod[2] = '{24, 12};
   int          m_secs[2];
   bit          m_running[2], m_loading[2], m_dw[2], m_le[2], m_ah[2];
   logic [15:0] m_alarm[2];

   clock_time_counter #(.HOUR_MOD(24)) dut24 (
      .clk(clk), .rst(rst), .tick(tick), .run(run),
      .load_valid(load_valid), .load_ready(rdy24), .load_time(load_time),
      .load_err(err24), .time_bcd(t24),
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
      .alarm_set(alarm_set), .alarm_time(alarm_time), .alarm_on(alarm_on), .alarm_hit(ah24),
`endif
      .day_wrap(dw24)
   );

   clock_time_counter #(.HOUR_MOD(12)) dut12 (
      .clk(clk), .rst(rst), .tick(tick), .run(run),
      .load_valid(load_valid), .load_ready(rdy12), .load_time(load_time),
      .load_err(err12), .time_bcd(t12),
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
      .alarm_set(alarm_set), .alarm_time(alarm_time), .alarm_on(alarm_on), .alarm_hit(ah12),
`endif
      .day_wrap(dw12)
   );

   function automatic logic [23:0] to_bcd(int s);
      int h, m, x;
      h = s / 3600;
      m = (s / 60) % 60;
      x = s % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   // Seconds of day for a legal BCD time, -1 when the load must be rejected.
   function automatic int decode(logic [23:0] v, int hm);
      int d[6];
      for (int i = 0; i < 6; i++) d[i] = int'(v[i*4 +: 4]);
      for (int i = 0; i < 6; i++) if (d[i] > 9) return -1;
      if (d[1] > 5 || d[3] > 5) return -1;
      if (d[5] * 10 + d[4] >= hm) return -1;
      return (d[5] * 10 + d[4]) * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
   endfunction

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit          counting;
         bit          hs;
         int          dec;
         logic [23:0] tb;
         counting = m_running[k] && !m_loading[k];
         hs       = load_valid && !m_loading[k];
         dec      = decode(load_time, hmod[k]);
         m_dw[k]  = 1'b0;
         m_le[k]  = 1'b0;
         m_ah[k]  = 1'b0;
         if (rst) begin
            m_secs[k]    = 0;
            m_running[k] = 1'b0;
            m_loading[k] = 1'b0;
            m_alarm[k]   = 16'h0000;
         end else begin
            if (hs && dec >= 0) begin
               m_secs[k]    = dec;
               m_loading[k] = 1'b1;
            end else begin
               if (hs) begin
                  m_le[k] = 1'b1;
               end else if (tick && counting) begin
                  m_secs[k] = (m_secs[k] + 1) % (hmod[k] * 3600);
                  if (m_secs[k] == 0) m_dw[k] = 1'b1;
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
                  tb = to_bcd(m_secs[k]);
                  if (alarm_on && (m_secs[k] % 60 == 0) && (tb[23:8] == m_alarm[k])) m_ah[k] = 1'b1;
`endif
               end
               m_loading[k] = 1'b0;
               m_running[k] = run;
            end
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
            if (alarm_set) m_alarm[k] = alarm_time;
`endif
         end
      end
   endtask

   task automatic chk(string tag, logic [23:0] obs, logic [23:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply current inputs for one clock, then compare every output with the model.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("time24", t24, to_bcd(m_secs[0]));
      chk("time12", t12, to_bcd(m_secs[1]));
      chk("ready24", 24'(rdy24), 24'(!m_loading[0]));
      chk("ready12", 24'(rdy12), 24'(!m_loading[1]));
      chk("err24", 24'(err24), 24'(m_le[0]));
      chk("err12", 24'(err12), 24'(m_le[1]));
      chk("wrap24", 24'(dw24), 24'(m_dw[0]));
      chk("wrap12", 24'(dw12), 24'(m_dw[1]));
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
      chk("alarm24", 24'(ah24), 24'(m_ah[0]));
      chk("alarm12", 24'(ah12), 24'(m_ah[1]));
`endif
   endtask

   task automatic do_load(logic [23:0] v, logic with_tick);
      load_valid = 1'b1;
      load_time  = v;
      tick       = with_tick;
      cycle();
      load_valid = 1'b0;
      cycle();
      tick       = 1'b0;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; tick = 1'b0; load_valid = 1'b0; load_time = 24'h000000;
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
      alarm_set = 1'b0; alarm_on = 1'b0; alarm_time = 16'h0000;
`endif
      cycle();
      cycle();
      chk("reset_time", t24, 24'h000000);
      chk("reset_ready", 24'(rdy24), 24'h000001);
      rst = 1'b0;
      cycle();
      chk("ready_after_rst", 24'(rdy24), 24'h000001);

      // 60 ticks from midnight land on 00:01:00
      run = 1'b1;
      cycle();
      for (int i = 0; i < 60; i++) begin
         tick = 1'b1; cycle();
         tick = 1'b0; cycle();
      end
      chk("one_minute24", t24, 24'h000100);
      chk("one_minute12", t12, 24'h000100);

      // 23:59:59 rollover on the 24-hour instance; 12-hour instance rejects it
      load_valid = 1'b1; load_time = 24'h235959;
      cycle();
      chk("reject2359_12", 24'(err12), 24'h000001);
      load_valid = 1'b0;
      cycle();
      tick = 1'b1; cycle(); tick = 1'b0;
      chk("rollover24", t24, 24'h000000);
      chk("daywrap24_on", 24'(dw24), 24'h000001);
      cycle();
      chk("daywrap24_off", 24'(dw24), 24'h000000);

      // 11:59:59 rollover on the 12-hour instance, then an out-of-range 12:00:00
      do_load(24'h115959, 1'b0);
      tick = 1'b1; cycle(); tick = 1'b0;
      chk("rollover12", t12, 24'h000000);
      chk("daywrap12_on", 24'(dw12), 24'h000001);
      chk("noon24", t24, 24'h120000);
      load_valid = 1'b1; load_time = 24'h120000;
      cycle();
      chk("reject1200_12", 24'(err12), 24'h000001);
      chk("hold1200_12", t12, 24'h000000);
      load_valid = 1'b0;
      cycle();

      // illegal digit, then loads that win over a coincident tick
      load_valid = 1'b1; load_time = 24'h006A00;
      cycle();
      chk("reject6A_24", 24'(err24), 24'h000001);
      chk("hold6A_24", t24, 24'h120000);
      load_valid = 1'b0;
      cycle();
      do_load(24'h123456, 1'b1);
      chk("load_vs_tick24", t24, 24'h123456);
      do_load(24'h013456, 1'b1);
      chk("load_vs_tick12", t12, 24'h013456);

      // stopped clock ignores ticks
      run = 1'b0;
      cycle();
      tick = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      tick = 1'b0;
      chk("stopped24", t24, 24'h013456);

      // reset during the LOAD cycle discards the load
      load_valid = 1'b1; load_time = 24'h083000;
      cycle();
      load_valid = 1'b0; rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_in_load_time", t24, 24'h000000);
      chk("rst_in_load_ready", 24'(rdy24), 24'h000001);
      run = 1'b1; tick = 1'b1;
      cycle();
      tick = 1'b0;
      chk("stop_after_rst", t24, 24'h000000);

`ifdef CLOCK_TIME_COUNTER_ALARM_EN
      alarm_set = 1'b1; alarm_time = 16'h0700; alarm_on = 1'b1;
      cycle();
      alarm_set = 1'b0;
      do_load(24'h065959, 1'b0);
      tick = 1'b1; cycle(); tick = 1'b0;
      chk("alarm_hit24", 24'(ah24), 24'h000001);
      chk("alarm_hit12", 24'(ah12), 24'h000001);
      cycle();
      chk("alarm_once24", 24'(ah24), 24'h000000);
      do_load(24'h070000, 1'b0);
      chk("alarm_no_load", 24'(ah24), 24'h000000);
`endif

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int unsigned pick;
         rst  = ($urandom_range(0, 199) == 0);
         tick = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) run = ~run;
         load_valid = ($urandom_range(0, 7) == 0);
         pick = $urandom_range(0, 3);
         case (pick)
            0:       load_time = 24'($urandom);
            1:       load_time = to_bcd(86399 - int'($urandom_range(0, 3)));
            2:       load_time = to_bcd(43199 - int'($urandom_range(0, 3)));
            default: load_time = to_bcd(int'($urandom_range(0, 86399)));
         endcase
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
         alarm_on = 1'($urandom_range(0, 1));
`endif
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
